// File: rtl/umem_ctrl.sv
// umem_ctrl: sequences MIR RD/WR levels into a REQ/ACK memory transaction,
// stalling the microsequencer until it completes or times out.
module umem_ctrl #(
    parameter int DATA_BUS_WIDTH    = 32,
    parameter int ADDR_BUS_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES    = 15,
    parameter int TIMEOUT_BUS_WIDTH = 4
) (
    input  logic                      umem_ctrl_CLOCK_50,
    input  logic                      umem_ctrl_RESET_InHigh,
    input  logic                      umem_ctrl_RD_IN,
    input  logic                      umem_ctrl_WR_IN,
    input  logic [ADDR_BUS_WIDTH-1:0] umem_ctrl_ADDR_IN,
    input  logic [DATA_BUS_WIDTH-1:0] umem_ctrl_DATA_IN,
    output logic [DATA_BUS_WIDTH-1:0] umem_ctrl_DATA_OUT,
    output logic                      umem_ctrl_STALL_OUT,
    output logic                      umem_ctrl_ERR_OUT,
    output logic                      umem_ctrl_MEM_REQ_OUT,
    output logic                      umem_ctrl_MEM_WE_OUT,
    output logic [ADDR_BUS_WIDTH-1:0] umem_ctrl_MEM_ADDR_OUT,
    output logic [DATA_BUS_WIDTH-1:0] umem_ctrl_MEM_DATA_OUT,
    input  logic [DATA_BUS_WIDTH-1:0] umem_ctrl_MEM_DATA_IN,
    input  logic                      umem_ctrl_MEM_ACK_IN
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    localparam logic [TIMEOUT_BUS_WIDTH-1:0] LIMIT = TIMEOUT_BUS_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [TIMEOUT_BUS_WIDTH-1:0] r_cnt;
    logic [DATA_BUS_WIDTH-1:0]   r_dout;
    logic [ADDR_BUS_WIDTH-1:0]   r_addr;
    logic [DATA_BUS_WIDTH-1:0]   r_wdata;
    logic                        r_we;
    logic                        r_req;
    logic                        r_err;
    logic                        w_start;
    logic                        w_ack;

    assign w_start = (r_state == S_IDLE) && (umem_ctrl_RD_IN || umem_ctrl_WR_IN);
    assign w_ack   = (r_state == S_REQ) && umem_ctrl_MEM_ACK_IN;

    always_ff @(posedge umem_ctrl_CLOCK_50 or posedge umem_ctrl_RESET_InHigh) begin
        if (umem_ctrl_RESET_InHigh)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ACK is tested before the limit so a last-cycle acknowledge completes normally
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_REQ : S_IDLE;
            S_REQ:   w_next = w_ack ? S_DONE : (r_cnt == LIMIT ? S_ERR : S_REQ);
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge umem_ctrl_CLOCK_50 or posedge umem_ctrl_RESET_InHigh) begin
        if (umem_ctrl_RESET_InHigh) begin
            r_cnt   <= '0;
            r_dout  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr  <= umem_ctrl_ADDR_IN;
                r_wdata <= umem_ctrl_DATA_IN;
                r_we    <= umem_ctrl_WR_IN;
            end
            r_cnt <= w_start ? '0 : (r_state == S_REQ ? r_cnt + 1'b1 : r_cnt);
            if (w_ack && !r_we)
                r_dout <= umem_ctrl_MEM_DATA_IN;
            r_req <= (w_next == S_REQ);
            r_err <= (w_next == S_ERR);
        end
    end

    assign umem_ctrl_STALL_OUT    = !umem_ctrl_RESET_InHigh && (w_start || r_state == S_REQ);
    assign umem_ctrl_DATA_OUT     = r_dout;
    assign umem_ctrl_ERR_OUT      = r_err;
    assign umem_ctrl_MEM_REQ_OUT  = r_req;
    assign umem_ctrl_MEM_WE_OUT   = r_we;
    assign umem_ctrl_MEM_ADDR_OUT = r_addr;
    assign umem_ctrl_MEM_DATA_OUT = r_wdata;
endmodule

// File: tb/tb_umem_ctrl.sv
// tb_umem_ctrl: directed accesses with a scoreboard that checks each
// completed REQ window (DONE or ERR cycle) against queued expectations.
module tb_umem_ctrl;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic [31:0] dout;
    logic        stall;
    logic        err;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] mrdata = 32'hBAD0BAD0;
    logic        ack = 1'b0;

    umem_ctrl dut (
        .umem_ctrl_CLOCK_50     (clk),
        .umem_ctrl_RESET_InHigh (rst),
        .umem_ctrl_RD_IN        (rd),
        .umem_ctrl_WR_IN        (wr),
        .umem_ctrl_ADDR_IN      (addr_in),
        .umem_ctrl_DATA_IN      (data_in),
        .umem_ctrl_DATA_OUT     (dout),
        .umem_ctrl_STALL_OUT    (stall),
        .umem_ctrl_ERR_OUT      (err),
        .umem_ctrl_MEM_REQ_OUT  (req),
        .umem_ctrl_MEM_WE_OUT   (we),
        .umem_ctrl_MEM_ADDR_OUT (maddr),
        .umem_ctrl_MEM_DATA_OUT (mwdata),
        .umem_ctrl_MEM_DATA_IN  (mrdata),
        .umem_ctrl_MEM_ACK_IN   (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] dout;
        int          cycles;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: tracks each REQ window and scores it on the first cycle after REQ drops
    int          req_cnt = 0;
    int          stall_cnt = 0;
    int          low_cnt = 2;
    logic        prev_req = 1'b0;
    logic [31:0] a0, d0;
    logic        w0;

    always @(negedge clk) begin
        if (rst) begin
            req_cnt   = 0;
            stall_cnt = 0;
            low_cnt   = 2;
            prev_req  = 1'b0;
        end else begin
            if (req) begin
                if (!prev_req) begin
                    chk("req_gap_ge2", 32'(low_cnt >= 2), 32'd1);
                    a0 = maddr;
                    d0 = mwdata;
                    w0 = we;
                end else begin
                    chk("addr_stable", maddr, a0);
                    chk("wdata_stable", mwdata, d0);
                    chk("we_stable", 32'(we), 32'(w0));
                end
                chk("stall_in_req", 32'(stall), 32'd1);
                req_cnt++;
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            if (stall)
                stall_cnt++;
            if (prev_req && !req) begin
                if (q.size() == 0) begin
                    chk("unexpected_access", 32'd0, 32'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("err_out", 32'(err), 32'(e.err));
                    chk("data_out", dout, e.dout);
                    chk("req_cycles", 32'(req_cnt), 32'(e.cycles));
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.cycles + 1));
                    chk("stall_end", 32'(stall), 32'd0);
                    chk("mem_we", 32'(w0), 32'(e.we));
                    chk("mem_addr", a0, e.addr);
                    chk("mem_wdata", d0, e.wdata);
                end
                req_cnt   = 0;
                stall_cnt = 0;
            end else begin
                chk("err_spurious", 32'(err), 32'd0);
            end
            prev_req = req;
        end
    end

    // ack_cyc: REQ cycle (1-based) that carries ACK; 0 means never acknowledged
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int ack_cyc, input logic [31:0] rdat);
        exp_t e;
        e.err    = (ack_cyc == 0);
        e.cycles = (ack_cyc == 0) ? TO : ack_cyc;
        e.we     = w;
        e.addr   = a;
        e.wdata  = d;
        if (ack_cyc != 0 && !w)
            exp_dout = rdat;
        e.dout = exp_dout;
        q.push_back(e);
        rd      = r;
        wr      = w;
        addr_in = a;
        data_in = d;
        @(posedge clk); #1;
        for (int k = 1; k <= TO; k++) begin
            if (k == ack_cyc) begin
                ack    = 1'b1;
                mrdata = rdat;
            end
            @(posedge clk); #1;
            ack    = 1'b0;
            mrdata = 32'hBAD0BAD0;
            if (k == ack_cyc)
                break;
        end
        @(posedge clk); #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rd = 1'b1;
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_addr", maddr, 32'd0);
        rd = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'h200, 32'h12345678, 4, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0);
        access(1'b1, 1'b0, 32'h304, 32'h0, TO, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h400, 32'h0, 2, 32'h11111111);
        access(1'b1, 1'b0, 32'h404, 32'h0, 1, 32'h22222222);
        access(1'b1, 1'b1, 32'h500, 32'hA5A5A5A5, 1, 32'h99999999);

        // reset mid-access: abort in the second REQ cycle
        rd      = 1'b1;
        addr_in = 32'h600;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_dout", dout, 32'd0);
        chk("midrst_addr", maddr, 32'd0);
        chk("midrst_wdata", mwdata, 32'd0);
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ack    = 1'b1;
        mrdata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("late_ack_req", 32'(req), 32'd0);
            chk("late_ack_stall", 32'(stall), 32'd0);
            chk("late_ack_dout", dout, 32'd0);
            @(posedge clk); #1;
        end
        ack = 1'b0;

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/umem_ctrl.md
# umem_ctrl

Main-memory access sequencer for the microprogrammed datapath. It turns the level RD/WR fields driven by the MIR into a request/acknowledge transaction on the memory port. While the transaction is in flight it stalls the microsequencer, so the CS address incrementer and the MIR hold the current microinstruction. It also captures read data for the datapath and aborts accesses that are never acknowledged.

## Interface

Parameters:
- DATA_BUS_WIDTH, 32: datapath/memory data width.
- ADDR_BUS_WIDTH, 32: memory address width.
- TIMEOUT_CYCLES, 15: maximum REQ cycles before abort; legal range 1..2^TIMEOUT_BUS_WIDTH.
- TIMEOUT_BUS_WIDTH, 4: wait counter width.

Ports:
- umem_ctrl_CLOCK_50, input, 1: the block's single clock, rising edge.
- umem_ctrl_RESET_InHigh, input, 1: asynchronous, active-high reset.
- umem_ctrl_RD_IN, input, 1: read field of the MIR, level.
- umem_ctrl_WR_IN, input, 1: write field of the MIR, level.
- umem_ctrl_ADDR_IN, input, ADDR_BUS_WIDTH: address from the datapath A bus.
- umem_ctrl_DATA_IN, input, DATA_BUS_WIDTH: write data from the datapath B bus.
- umem_ctrl_DATA_OUT, output, DATA_BUS_WIDTH: registered read data to the C-bus MUX.
- umem_ctrl_STALL_OUT, output, 1: holds CSAI and MIR when high.
- umem_ctrl_ERR_OUT, output, 1: one-cycle timeout pulse.
- umem_ctrl_MEM_REQ_OUT, output, 1: memory request.
- umem_ctrl_MEM_WE_OUT, output, 1: 1 = write, 0 = read; valid while REQ is high.
- umem_ctrl_MEM_ADDR_OUT, output, ADDR_BUS_WIDTH: latched address.
- umem_ctrl_MEM_DATA_OUT, output, DATA_BUS_WIDTH: latched write data.
- umem_ctrl_MEM_DATA_IN, input, DATA_BUS_WIDTH: read data; valid when ACK is high.
- umem_ctrl_MEM_ACK_IN, input, 1: memory acknowledge, sampled only in REQ.

## Operation

- The FSM has four states: IDLE, REQ, DONE, ERR.
- **IDLE**
  - If RD or WR is high, latch ADDR_IN into MEM_ADDR_OUT, DATA_IN into MEM_DATA_OUT, and WR_IN into MEM_WE_OUT.
  - Clear the wait counter and go to REQ. Otherwise stay in IDLE.
- **Simultaneous RD and WR:** treated as a write.
- **REQ**
  - MEM_REQ_OUT = 1. Address, data and WE are stable for the whole state.
  - ACK = 1: if it is a read, load MEM_DATA_IN into DATA_OUT; go to DONE.
  - ACK = 0 and counter == TIMEOUT_CYCLES-1: go to ERR.
  - Otherwise increment the counter.
  - When ACK arrives in the same cycle as the limit, ACK wins.
- **DONE:** unconditionally go to IDLE. RD/WR are still high for the same microinstruction and are ignored here; this prevents a double access.
- **ERR:** ERR_OUT = 1 and DATA_OUT is unchanged. Unconditionally go to IDLE.
- **STALL_OUT** is combinational: (IDLE and (RD or WR)) or REQ. It is 0 in DONE and ERR, so the MIR advances at the end of those cycles.
- **Writes** never modify DATA_OUT.
- **ACK outside REQ** is ignored.
- **Reset**
  - State goes to IDLE and all registered outputs go to 0: DATA_OUT, MEM_ADDR_OUT, MEM_DATA_OUT, MEM_WE_OUT, MEM_REQ_OUT, ERR_OUT.
  - STALL_OUT is forced to 0 while reset is high.
  - Reset during REQ drops MEM_REQ_OUT immediately (asynchronous) and no data is captured.

## Timing

- **Minimum access, ACK in the first REQ cycle:**
  - Cycle 0: IDLE, stalled.
  - Cycle 1: REQ, ACK high.
  - Cycle 2: DONE, DATA_OUT valid, no stall.
  - The next microinstruction loads at the end of cycle 2, so a memory microinstruction occupies 3 cycles, plus any wait cycles.
- **Each cycle of ACK delay** adds one REQ cycle.
- **Timeout:** TIMEOUT_CYCLES REQ cycles, then one ERR cycle. Total 2 + TIMEOUT_CYCLES cycles.
- **Back-to-back accesses:** the IDLE cycle after DONE can start the next access. MEM_REQ_OUT is low for at least 2 cycles (DONE and IDLE) between requests.
- MEM_REQ_OUT, MEM_WE_OUT, MEM_ADDR_OUT, MEM_DATA_OUT and DATA_OUT are registered. STALL_OUT is combinational from state and RD/WR.

## Test plan

- **Zero-wait read.** RD=1, ADDR=0x100, memory ACKs in the first REQ cycle with 0xDEADBEEF. Expect: STALL high for 2 cycles, MEM_WE=0, DATA_OUT=0xDEADBEEF in DONE, exactly one REQ pulse.
- **Write with 3 wait cycles.** WR=1, ADDR=0x200, DATA=0x12345678, ACK on the 4th REQ cycle. Expect: MEM_WE=1, address and data stable for all 4 REQ cycles, STALL high for 5 cycles, DATA_OUT unchanged.
- **Timeout.** RD=1 and ACK never asserted, default parameters. Expect: 15 REQ cycles, then ERR_OUT high for exactly 1 cycle, STALL low in ERR, return to IDLE, DATA_OUT unchanged.
- **ACK on the limit cycle.** ACK arrives on REQ cycle 15. Expect: DONE, not ERR; ERR_OUT stays 0; data captured.
- **Back-to-back and RD+WR.**
  - Two consecutive read microinstructions: two separate REQ windows, with MEM_REQ low for 2 cycles between them, and no double access in DONE.
  - RD=WR=1: a single write.
- **Reset mid-access.** Assert reset in REQ cycle 2. Expect: MEM_REQ_OUT=0 immediately, STALL=0, all outputs 0. After release with RD=0, stays in IDLE and a late ACK is ignored.
